// File: rtl/event_serializer.sv
// Event serializer: on a scintillator coincidence, waits out the drift window,
// snapshots the 32 tube times and writes a framed, zero-suppressed event to the FIFO.
module event_serializer #(
  parameter int WINDOW_CYCLES = 256,
  parameter int CLR_CYCLES    = 11,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic         clk50,
  input  logic         rst_n,
  input  logic         scin_coin,
  input  logic [255:0] tube_data,
  input  logic         fifo_full,
  output logic [15:0]  fifo_din,
  output logic         fifo_wr_en,
  output logic         tube_clr,
  output logic         busy,
  output logic [7:0]   event_cnt,
  output logic [7:0]   missed_cnt
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WINDOW, S_HEADER, S_SCAN, S_TRAILER, S_CLEAR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_coin_prev;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [CLR_W-1:0]   r_clr_cnt;
  logic [255:0]       r_snap;
  logic [4:0]         r_idx;
  logic [5:0]         r_hits;
  logic [7:0]         r_event_cnt;
  logic [7:0]         r_missed_cnt;

  logic               w_edge;
  logic               w_win_last;
  logic               w_clr_last;
  logic [7:0]         w_time;
  logic [7:0]         w_name;
  logic               w_skip;
  logic               w_pending;
  logic [15:0]        w_din;
  logic               w_accept;
  logic               w_scan_adv;

  assign w_edge     = scin_coin & ~r_coin_prev;
  assign w_win_last = (r_win_cnt == WIN_LAST);
  assign w_clr_last = (r_clr_cnt == CLR_LAST);
  assign w_time     = r_snap[{r_idx, 3'b000} +: 8];
  // Tube name: channel, side (A/B), chamber number 3 or 4 in the low nibble.
  assign w_name     = {r_idx[2:0], r_idx[3], 4'd3 + {3'b000, r_idx[4]}};
  assign w_skip     = ZERO_SUPPRESS && (w_time == 8'h00);
  assign w_accept   = w_pending & ~fifo_full;
  assign w_scan_adv = (r_state == S_SCAN) && (w_skip || w_accept);

  assign fifo_din   = w_din;
  assign fifo_wr_en = w_accept;
  assign tube_clr   = (r_state == S_CLEAR);
  assign busy       = (r_state != S_IDLE);
  assign event_cnt  = r_event_cnt;
  assign missed_cnt = r_missed_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_pending = 1'b0;
    w_din     = 16'h0000;
    case (r_state)
      S_IDLE:    if (w_edge) w_next = S_WINDOW;
      S_WINDOW:  if (w_win_last) w_next = S_HEADER;
      S_HEADER: begin
        w_pending = 1'b1;
        w_din     = {r_event_cnt, 8'hFF};
        if (!fifo_full) w_next = S_SCAN;
      end
      S_SCAN: begin
        w_pending = ~w_skip;
        w_din     = {w_time, w_name};
        if ((w_skip || !fifo_full) && (r_idx == 5'd31)) w_next = S_TRAILER;
      end
      S_TRAILER: begin
        w_pending = 1'b1;
        w_din     = {2'b00, r_hits, 8'hFE};
        if (!fifo_full) w_next = S_CLEAR;
      end
      S_CLEAR:   if (w_clr_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: the snapshot is wide but is still reset, so a reset mid-event leaves no stale times.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_coin_prev  <= 1'b1;
      r_win_cnt    <= '0;
      r_clr_cnt    <= '0;
      r_snap       <= '0;
      r_idx        <= '0;
      r_hits       <= '0;
      r_event_cnt  <= '0;
      r_missed_cnt <= '0;
    end else begin
      r_coin_prev <= scin_coin;
      if (w_edge && (r_state != S_IDLE) && (r_missed_cnt != 8'hFF))
        r_missed_cnt <= r_missed_cnt + 8'd1;
      case (r_state)
        S_IDLE:   r_win_cnt <= '0;
        S_WINDOW: begin
          r_win_cnt <= r_win_cnt + WIN_W'(1);
          if (w_win_last) r_snap <= tube_data;
        end
        S_HEADER: begin
          if (w_accept) begin
            r_event_cnt <= r_event_cnt + 8'd1;
            r_idx       <= '0;
            r_hits      <= '0;
          end
        end
        S_SCAN: begin
          if (w_scan_adv) r_idx  <= r_idx + 5'd1;
          if (w_accept)   r_hits <= r_hits + 6'd1;
        end
        S_TRAILER: r_clr_cnt <= '0;
        S_CLEAR:   r_clr_cnt <= r_clr_cnt + CLR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_event_serializer.sv
// Directed bench for event_serializer: a default-parameter instance and a short-window,
// no-suppression instance used for the all-zero frame and header wrap.
module tb_event_serializer;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic         rst_n;
  logic         coin1, full1, wr1, clr1, busy1;
  logic [255:0] tube1;
  logic [15:0]  din1;
  logic [7:0]   ecnt1, mcnt1;
  logic         coin2, full2, wr2, clr2, busy2;
  logic [255:0] tube2;
  logic [15:0]  din2;
  logic [7:0]   ecnt2, mcnt2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  event_serializer dut1 (
    .clk50(clk50), .rst_n(rst_n), .scin_coin(coin1), .tube_data(tube1), .fifo_full(full1),
    .fifo_din(din1), .fifo_wr_en(wr1), .tube_clr(clr1), .busy(busy1),
    .event_cnt(ecnt1), .missed_cnt(mcnt1)
  );

  event_serializer #(.WINDOW_CYCLES(4), .CLR_CYCLES(2), .ZERO_SUPPRESS(1'b0)) dut2 (
    .clk50(clk50), .rst_n(rst_n), .scin_coin(coin2), .tube_data(tube2), .fifo_full(full2),
    .fifo_din(din2), .fifo_wr_en(wr2), .tube_clr(clr2), .busy(busy2),
    .event_cnt(ecnt2), .missed_cnt(mcnt2)
  );

  always @(posedge clk50) cyc <= cyc + 1;

  // Accepted words with the clock index of the accepting edge; tube_clr high-cycle count.
  logic [15:0] q1_w[$];
  int          q1_c[$];
  logic [15:0] q2_w[$];
  int          clr1_n = 0;

  always @(negedge clk50) begin
    if (wr1) begin
      q1_w.push_back(din1);
      q1_c.push_back(cyc + 1);
    end
    if (wr2) q2_w.push_back(din2);
    if (clr1) clr1_n <= clr1_n + 1;
  end

  function automatic logic [7:0] tname(input int i);
    logic [4:0] b;
    b = i[4:0];
    return {b[2:0], b[3], 4'd3 + {3'b000, b[4]}};
  endfunction

  task automatic pulse1(output int e);
    @(posedge clk50); #1 coin1 = 1'b1;
    e = cyc + 1;
    @(posedge clk50); #1 coin1 = 1'b0;
  endtask

  task automatic pulse2();
    @(posedge clk50); #1 coin2 = 1'b1;
    @(posedge clk50); #1 coin2 = 1'b0;
  endtask

  task automatic wait_idle1(input int budget);
    int k = 0;
    @(negedge clk50);
    while (busy1 && k < budget) begin @(negedge clk50); k++; end
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout1: busy=%b after %0d cycles, want 0", busy1, budget);
    end
  endtask

  task automatic wait_idle2(input int budget);
    int k = 0;
    @(negedge clk50);
    while (busy2 && k < budget) begin @(negedge clk50); k++; end
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout2: busy=%b after %0d cycles, want 0", busy2, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coin1 = 1'b1; coin2 = 1'b0; full1 = 1'b0; full2 = 1'b0;
    tube1 = '0; tube2 = '0;
    #25;
    n_cmp++;
    if ({din1, wr1, clr1, busy1, ecnt1, mcnt1, din2, wr2, clr2, busy2, ecnt2, mcnt2} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_outputs: din1=%h wr1=%b clr1=%b busy1=%b ecnt1=%0d mcnt1=%0d busy2=%b, want all 0",
               din1, wr1, clr1, busy1, ecnt1, mcnt1, busy2);
    end
    @(posedge clk50); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk50);
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL coin_high_at_release: busy=%b, want 0", busy1);
    end
    @(posedge clk50); #1 coin1 = 1'b0;
  endtask

  task automatic test_single();
    logic [15:0] exp[3] = '{16'h00FF, 16'h1723, 16'h01FE};
    int s, c0, e;
    tube1 = '0; tube1[15:8] = 8'h17;
    s = q1_w.size(); c0 = clr1_n;
    pulse1(e);
    wait_idle1(1000);
    n_cmp++;
    if (q1_w.size() - s !== 3) begin
      n_err++; $display("FAIL single_count: got %0d words, want 3", q1_w.size() - s);
    end
    for (int i = 0; i < 3; i++) begin
      if (s + i < q1_w.size()) begin
        n_cmp++;
        if (q1_w[s+i] !== exp[i]) begin
          n_err++; $display("FAIL single_word%0d: got %h, want %h", i, q1_w[s+i], exp[i]);
        end
      end
    end
    if (s < q1_c.size()) begin
      n_cmp++;
      if (q1_c[s] !== e + 257) begin
        n_err++; $display("FAIL header_latency: accepted at clock %0d, want %0d", q1_c[s] - e, 257);
      end
    end
    n_cmp++;
    if (clr1_n - c0 !== 11) begin
      n_err++; $display("FAIL clr_length: tube_clr high %0d cycles, want 11", clr1_n - c0);
    end
    n_cmp++;
    if (ecnt1 !== 8'd1 || mcnt1 !== 8'd0) begin
      n_err++; $display("FAIL single_counters: event_cnt=%0d missed_cnt=%0d, want 1 0", ecnt1, mcnt1);
    end
  endtask

  task automatic test_all_hits();
    logic [15:0] exp[34];
    int s, e;
    for (int i = 0; i < 32; i++) tube1[8*i +: 8] = 8'(i + 1);
    exp[0] = 16'h01FF;
    for (int i = 0; i < 32; i++) exp[i+1] = {8'(i + 1), tname(i)};
    exp[33] = 16'h20FE;
    s = q1_w.size();
    pulse1(e);
    wait_idle1(1000);
    n_cmp++;
    if (q1_w.size() - s !== 34) begin
      n_err++; $display("FAIL allhits_count: got %0d words, want 34", q1_w.size() - s);
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (q1_w[s+i] !== exp[i]) begin
          n_err++; $display("FAIL allhits_word%0d: got %h, want %h", i, q1_w[s+i], exp[i]);
        end
      end
      n_cmp++;
      if (q1_w[s+1] !== 16'h0103 || q1_w[s+32] !== 16'h20F4 || q1_w[s+33] !== 16'h20FE) begin
        n_err++; $display("FAIL allhits_anchor: got %h %h %h, want 0103 20F4 20FE",
                          q1_w[s+1], q1_w[s+32], q1_w[s+33]);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [15:0] exp[34];
    int s, e, k, bad;
    exp[0] = 16'h02FF;
    for (int i = 0; i < 32; i++) exp[i+1] = {8'(i + 1), tname(i)};
    exp[33] = 16'h20FE;
    s = q1_w.size();
    pulse1(e);
    k = 0;
    @(negedge clk50);
    while (!(wr1 && din1 === 16'h0B53) && k < 1000) begin @(negedge clk50); k++; end
    n_cmp++;
    if (!(wr1 && din1 === 16'h0B53)) begin
      n_err++; $display("FAIL stall_reach_idx10: din=%h wr=%b, want 0b53 1", din1, wr1);
    end
    @(posedge clk50); #1 full1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk50);
      n_cmp++;
      if (wr1 !== 1'b0 || din1 !== 16'h0C73 || clr1 !== 1'b0) begin
        n_err++; bad++;
        if (bad < 4) $display("FAIL stall_hold: wr=%b din=%h clr=%b, want 0 0c73 0", wr1, din1, clr1);
      end
    end
    @(posedge clk50); #1 full1 = 1'b0;
    wait_idle1(1000);
    n_cmp++;
    if (q1_w.size() - s !== 34) begin
      n_err++; $display("FAIL stall_count: got %0d words, want 34", q1_w.size() - s);
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (q1_w[s+i] !== exp[i]) begin
          n_err++; $display("FAIL stall_word%0d: got %h, want %h", i, q1_w[s+i], exp[i]);
        end
      end
      n_cmp++;
      if (q1_c[s+12] - q1_c[s+11] !== 51) begin
        n_err++; $display("FAIL stall_gap: %0d clocks between tube10 and tube11, want 51",
                          q1_c[s+12] - q1_c[s+11]);
      end
    end
  endtask

  task automatic test_missed();
    logic [15:0] exp[3] = '{16'h03FF, 16'h1723, 16'h01FE};
    int s, e, d, k;
    tube1 = '0; tube1[15:8] = 8'h17;
    s = q1_w.size();
    pulse1(e);
    repeat (10) @(posedge clk50);
    pulse1(d);
    k = 0;
    @(negedge clk50);
    while (!clr1 && k < 1000) begin @(negedge clk50); k++; end
    n_cmp++;
    if (clr1 !== 1'b1) begin
      n_err++; $display("FAIL missed_reach_clear: tube_clr=%b, want 1", clr1);
    end
    pulse1(d);
    wait_idle1(100);
    n_cmp++;
    if (mcnt1 !== 8'd2 || ecnt1 !== 8'd4) begin
      n_err++; $display("FAIL missed_counters: missed_cnt=%0d event_cnt=%0d, want 2 4", mcnt1, ecnt1);
    end
    n_cmp++;
    if (q1_w.size() - s !== 3) begin
      n_err++; $display("FAIL missed_count: got %0d words, want 3", q1_w.size() - s);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q1_w[s+i] !== exp[i]) begin
          n_err++; $display("FAIL missed_word%0d: got %h, want %h", i, q1_w[s+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp[3] = '{16'h00FF, 16'h1723, 16'h01FE};
    int s, e, k;
    for (int i = 0; i < 32; i++) tube1[8*i +: 8] = 8'(i + 1);
    pulse1(e);
    k = 0;
    @(negedge clk50);
    while (!(wr1 && din1 === 16'h0B53) && k < 1000) begin @(negedge clk50); k++; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({din1, wr1, clr1, busy1, ecnt1, mcnt1} !== 35'h0) begin
      n_err++; $display("FAIL midreset_outputs: din=%h wr=%b clr=%b busy=%b ecnt=%0d mcnt=%0d, want all 0",
                        din1, wr1, clr1, busy1, ecnt1, mcnt1);
    end
    s = q1_w.size();
    @(posedge clk50); #1 rst_n = 1'b1;
    repeat (40) @(negedge clk50);
    n_cmp++;
    if (q1_w.size() !== s) begin
      n_err++; $display("FAIL midreset_no_trailer: %0d words after reset, want 0", q1_w.size() - s);
    end
    tube1 = '0; tube1[15:8] = 8'h17;
    pulse1(e);
    wait_idle1(1000);
    n_cmp++;
    if (q1_w.size() - s !== 3) begin
      n_err++; $display("FAIL midreset_count: got %0d words, want 3", q1_w.size() - s);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q1_w[s+i] !== exp[i]) begin
          n_err++; $display("FAIL midreset_word%0d: got %h, want %h", i, q1_w[s+i], exp[i]);
        end
      end
      n_cmp++;
      if (q1_c[s] !== e + 257) begin
        n_err++; $display("FAIL midreset_latency: header at clock %0d, want 257", q1_c[s] - e);
      end
    end
    n_cmp++;
    if (ecnt1 !== 8'd1) begin
      n_err++; $display("FAIL midreset_event_cnt: got %0d, want 1", ecnt1);
    end
  endtask

  task automatic test_no_suppress();
    logic [15:0] exp[34];
    int s;
    tube2 = '0;
    exp[0] = 16'h00FF;
    for (int i = 0; i < 32; i++) exp[i+1] = {8'h00, tname(i)};
    exp[33] = 16'h20FE;
    s = q2_w.size();
    pulse2();
    wait_idle2(200);
    n_cmp++;
    if (q2_w.size() - s !== 34) begin
      n_err++; $display("FAIL nozs_count: got %0d words, want 34", q2_w.size() - s);
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_cmp++;
        if (q2_w[s+i] !== exp[i]) begin
          n_err++; $display("FAIL nozs_word%0d: got %h, want %h", i, q2_w[s+i], exp[i]);
        end
      end
      n_cmp++;
      if (q2_w[s+1] !== 16'h0003 || q2_w[s+32] !== 16'h00F4) begin
        n_err++; $display("FAIL nozs_anchor: got %h %h, want 0003 00f4", q2_w[s+1], q2_w[s+32]);
      end
    end
  endtask

  task automatic test_wrap();
    int s;
    for (int n = 0; n < 254; n++) begin
      pulse2();
      wait_idle2(200);
    end
    s = q2_w.size();
    pulse2();
    wait_idle2(200);
    n_cmp++;
    if (q2_w.size() <= s || q2_w[s] !== 16'hFFFF || ecnt2 !== 8'd0) begin
      n_err++; $display("FAIL wrap_last_header: header=%h event_cnt=%0d, want ffff 0",
                        (q2_w.size() > s) ? q2_w[s] : 16'hxxxx, ecnt2);
    end
    s = q2_w.size();
    pulse2();
    wait_idle2(200);
    n_cmp++;
    if (q2_w.size() <= s || q2_w[s] !== 16'h00FF || ecnt2 !== 8'd1) begin
      n_err++; $display("FAIL wrap_first_header: header=%h event_cnt=%0d, want 00ff 1",
                        (q2_w.size() > s) ? q2_w[s] : 16'hxxxx, ecnt2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_hits();
    test_full_stall();
    test_missed();
    test_reset_mid();
    test_no_suppress();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
